mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory stage plus M/W pipeline register of the 5-stage MIPS core; sits directly downstream of the E/M register and consumes its outputs.
- Holds the data memory: word and byte stores, word and sign-extended byte loads.
- Selects the writeback value and registers it, with destination and Tnew, into the W stage.
- Also drives the M-stage forwarding value used by the hazard unit.

Parameters:
- DM_WORDS, 3072, number of 32-bit words in data memory (12 KiB).
- IDX_W, 12, word-index width; index = aluR_M[IDX_W+1:2].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  stage enable; 0 = hold W registers and block stores.
- MemtoReg_M  in  1  writeback selects load data.
- RegWrite_M  in  1  instruction writes the GRF.
- MemWrite_M  in  1  store instruction.
- Jal_M  in  1  writeback selects PC8_M.
- Byte_M  in  1  byte-sized access (sb/lb).
- PC_M  in  32  instruction PC.
- PC8_M  in  32  PC+8 link value.
- aluR_M  in  32  ALU result / effective address.
- RD2_M  in  32  store data, already forwarded by the caller.
- A3_M  in  5  destination register.
- Tnew_M  in  2  cycles until result is ready.
- Fwd_M  out  32  M-stage forward value: Jal_M ? PC8_M : aluR_M (combinational).
- RegWrite_W  out  1  registered RegWrite.
- A3_W  out  5  registered destination.
- WD_W  out  32  registered writeback data.
- PC_W  out  32  registered PC.
- Tnew_W  out  2  registered Tnew after decrement.

Behaviour:
- Reset (reset=1 at posedge): all W outputs become 0; every memory word becomes 0. Reset beats en and MemWrite_M; no store occurs that cycle.
- Address: idx = aluR_M[IDX_W+1:2]; lane = aluR_M[1:0]. Word accesses ignore aluR_M[1:0]. Address is out of range when idx >= DM_WORDS or aluR_M[31:IDX_W+2] != 0.
- Read (combinational): rdata = mem[idx]; 0 when out of range.
- Load value:
  - Byte_M=1: sign-extend rdata byte at lane, little endian (lane 0 = bits 7:0).
  - Byte_M=0: rdata.
- Store (posedge; requires en=1, reset=0, MemWrite_M=1, address in range):
  - Byte_M=0: mem[idx] <= RD2_M.
  - Byte_M=1: only the selected lane <= RD2_M[7:0]; other lanes unchanged (read-modify-write in the same cycle).
  - Out-of-range store: silently dropped.
- Writeback select, priority Jal > MemtoReg > ALU: wd = Jal_M ? PC8_M : (MemtoReg_M ? load value : aluR_M).
- W register, when en=1 and not reset, latency 1 cycle:
  - RegWrite_W <= RegWrite_M; A3_W <= A3_M; WD_W <= wd; PC_W <= PC_M.
  - Tnew_W <= (Tnew_M == 0) ? 0 : Tnew_M - 1 (saturating at 0).
- en=0: all W registers hold; memory unchanged even if MemWrite_M=1. This prevents a double store across a stall.
- Load after store to the same address: a store commits at the edge, so a load in the next cycle sees the new data. A load in the same M cycle as a store cannot occur (one instruction per stage).
- A3_M=0 with RegWrite_M=1 is passed through unchanged; the GRF ignores $0.

Optional Feature:
- Macro DM_DISPLAY_EN.
- Defined: on every committed store (same conditions as the write), print at the clock edge: $display("%d@%h: *%h <= %h", $time, PC_M, {aluR_M[31:2],2'b00}, new full word).
  - For sb, "new full word" is the merged word.
  - Dropped or stalled stores print nothing.
- Undefined: no display code is compiled; behaviour is otherwise identical.

Test Plan:
- Word round trip: reset; sw aluR=0x0000_0010, RD2=0xDEADBEEF; next cycle lw, same address, MemtoReg=1 -> WD_W=0xDEADBEEF one cycle later.
- Byte lanes: store word 0x11223344 @0x20; sb RD2=0x000000F5 @0x22 -> word reads 0x11F53344; lb @0x22 -> WD_W=0xFFFFFFF5; lb @0x20 -> WD_W=0x00000044.
- Jal priority: Jal=1, MemtoReg=1, PC8=0x00003008 -> WD_W=0x00003008 and Fwd_M=0x00003008; then Jal=0, MemtoReg=0, aluR=0x7 -> Fwd_M=0x7.
- Stall: en=0 with MemWrite=1 @0x40, data 0x5 -> memory unchanged and W outputs hold; en=1 next cycle -> exactly one store commits.
- Tnew and out of range:
  - Tnew_M 2/1/0 -> Tnew_W 1/0/0.
  - sw @0x0000_3000 (idx 3072) -> dropped; lw @0x0000_3000 -> WD_W=0.
- Reset mid-operation: reset=1 with MemWrite=1 @0x10 -> mem[4]=0 and all W outputs 0; a subsequent lw @0x10 -> 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory stage and M/W pipeline register: data memory, load/store, writeback select.
// Optional store trace is compiled in when DM_DISPLAY_EN is defined.
module mem_wb_stage #(
  parameter int DM_WORDS = 3072,
  parameter int IDX_W    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        MemtoReg_M,
  input  logic        RegWrite_M,
  input  logic        MemWrite_M,
  input  logic        Jal_M,
  input  logic        Byte_M,
  input  logic [31:0] PC_M,
  input  logic [31:0] PC8_M,
  input  logic [31:0] aluR_M,
  input  logic [31:0] RD2_M,
  input  logic [4:0]  A3_M,
  input  logic [1:0]  Tnew_M,
  output logic [31:0] Fwd_M,
  output logic        RegWrite_W,
  output logic [4:0]  A3_W,
  output logic [31:0] WD_W,
  output logic [31:0] PC_W,
  output logic [1:0]  Tnew_W
);

  localparam logic [IDX_W:0] DM_LIMIT = (IDX_W+1)'(DM_WORDS);

  logic [31:0]      mem_q [0:DM_WORDS-1];
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             in_range;
  logic [31:0]      rdata;
  logic [7:0]       rbyte;
  logic [31:0]      load_val;
  logic [31:0]      store_word;
  logic             store_en;
  logic [31:0]      wd;

  logic        reg_write_q, reg_write_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  tnew_q, tnew_d;

  assign idx      = aluR_M[IDX_W+1:2];
  assign lane     = aluR_M[1:0];
  assign in_range = (aluR_M[31:IDX_W+2] == '0) && ({1'b0, idx} < DM_LIMIT);
  assign rdata    = in_range ? mem_q[idx] : 32'd0;
  assign rbyte    = rdata[{lane, 3'b000} +: 8];
  assign load_val = Byte_M ? {{24{rbyte[7]}}, rbyte} : rdata;
  assign store_en = en && !reset && MemWrite_M && in_range;

  // Byte stores merge into the current word so the other lanes survive.
  always_comb begin
    store_word = RD2_M;
    if (Byte_M) begin
      store_word = rdata;
      store_word[{lane, 3'b000} +: 8] = RD2_M[7:0];
    end
  end

  assign Fwd_M = Jal_M ? PC8_M : aluR_M;
  assign wd    = Jal_M ? PC8_M : (MemtoReg_M ? load_val : aluR_M);

  always_comb begin
    reg_write_d = reg_write_q;
    a3_d        = a3_q;
    wd_d        = wd_q;
    pc_d        = pc_q;
    tnew_d      = tnew_q;
    if (en) begin
      reg_write_d = RegWrite_M;
      a3_d        = A3_M;
      wd_d        = wd;
      pc_d        = PC_M;
      tnew_d      = (Tnew_M == 2'd0) ? 2'd0 : Tnew_M - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      a3_q        <= 5'd0;
      wd_q        <= 32'd0;
      pc_q        <= 32'd0;
      tnew_q      <= 2'd0;
    end else begin
      reg_write_q <= reg_write_d;
      a3_q        <= a3_d;
      wd_q        <= wd_d;
      pc_q        <= pc_d;
      tnew_q      <= tnew_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= 32'd0;
    end else if (store_en) begin
      mem_q[idx] <= store_word;
    end
  end

`ifdef DM_DISPLAY_EN
  always @(posedge clk) begin
    if (store_en)
      $display("%d@%h: *%h <= %h", $time, PC_M, {aluR_M[31:2], 2'b00}, store_word);
  end
`else
`endif

  assign RegWrite_W = reg_write_q;
  assign A3_W       = a3_q;
  assign WD_W       = wd_q;
  assign PC_W       = pc_q;
  assign Tnew_W     = tnew_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed test-plan steps followed by randomized
// operations, all checked against a byte-addressed behavioural memory model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, en, MemtoReg_M, RegWrite_M, MemWrite_M, Jal_M, Byte_M;
  logic [31:0] PC_M, PC8_M, aluR_M, RD2_M;
  logic [4:0]  A3_M;
  logic [1:0]  Tnew_M;
  logic [31:0] Fwd_M;
  logic        RegWrite_W;
  logic [4:0]  A3_W;
  logic [31:0] WD_W, PC_W;
  logic [1:0]  Tnew_W;

  int checks   = 0;
  int failures = 0;

  localparam int unsigned MEM_BYTES = 3072 * 4;

  logic [31:0] mm [0:3071];
  logic        e_rw;
  logic [4:0]  e_a3;
  logic [31:0] e_wd, e_pc;
  logic [1:0]  e_tn;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .en(en),
    .MemtoReg_M(MemtoReg_M), .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M),
    .Jal_M(Jal_M), .Byte_M(Byte_M),
    .PC_M(PC_M), .PC8_M(PC8_M), .aluR_M(aluR_M), .RD2_M(RD2_M),
    .A3_M(A3_M), .Tnew_M(Tnew_M),
    .Fwd_M(Fwd_M), .RegWrite_W(RegWrite_W), .A3_W(A3_W),
    .WD_W(WD_W), .PC_W(PC_W), .Tnew_W(Tnew_W)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One pipeline cycle: drive, check Fwd_M, clock, update model, check W outputs.
  task automatic step(input string tag, input logic rst, input logic en_v,
                      input logic mtr, input logic rw, input logic mw,
                      input logic jal, input logic byt,
                      input logic [31:0] pc, input logic [31:0] pc8,
                      input logic [31:0] alu, input logic [31:0] d,
                      input logic [4:0] a3, input logic [1:0] tn);
    bit          hit;
    int unsigned w_i, ln;
    int          b;
    logic [31:0] word, load, wdv, mask;
    reset = rst; en = en_v; MemtoReg_M = mtr; RegWrite_M = rw; MemWrite_M = mw;
    Jal_M = jal; Byte_M = byt; PC_M = pc; PC8_M = pc8; aluR_M = alu; RD2_M = d;
    A3_M = a3; Tnew_M = tn;
    #1;
    chk({tag, ".Fwd"}, Fwd_M, jal ? pc8 : alu);

    hit  = (alu < MEM_BYTES);
    w_i  = alu / 4;
    ln   = alu % 4;
    word = hit ? mm[w_i] : 32'd0;
    b    = int'((word >> (8 * ln)) & 32'hFF);
    if (b > 127) b = b - 256;
    load = byt ? 32'(b) : word;
    wdv  = jal ? pc8 : (mtr ? load : alu);

    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 3072; i++) mm[i] = 32'd0;
      e_rw = 0; e_a3 = 0; e_wd = 0; e_pc = 0; e_tn = 0;
    end else if (en_v) begin
      if (mw && hit) begin
        if (byt) begin
          mask   = 32'hFF << (8 * ln);
          mm[w_i] = (mm[w_i] & ~mask) | ((d & 32'hFF) << (8 * ln));
        end else begin
          mm[w_i] = d;
        end
      end
      e_rw = rw; e_a3 = a3; e_wd = wdv; e_pc = pc;
      e_tn = (tn == 0) ? 2'd0 : 2'(tn - 1);
    end
    chk({tag, ".RegWrite_W"}, 32'(RegWrite_W), 32'(e_rw));
    chk({tag, ".A3_W"},       32'(A3_W),       32'(e_a3));
    chk({tag, ".WD_W"},       WD_W,            e_wd);
    chk({tag, ".PC_W"},       PC_W,            e_pc);
    chk({tag, ".Tnew_W"},     32'(Tnew_W),     32'(e_tn));
  endtask

  initial begin
    e_rw = 0; e_a3 = 0; e_wd = 0; e_pc = 0; e_tn = 0;
    for (int i = 0; i < 3072; i++) mm[i] = 32'hX;

    // rst en  mtr rw  mw  jal byt  pc  pc8  alu  data  a3  tn
    step("reset",    1, 1, 0, 1, 1, 0, 0, 32'h3000, 32'h3008, 32'h10, 32'h1234, 5'd3, 2'd2);
    chk("reset.WD_exact", WD_W, 32'd0);
    step("sw10",     0, 1, 0, 0, 1, 0, 0, 32'h3004, 32'h300C, 32'h10, 32'hDEADBEEF, 5'd0, 2'd0);
    step("lw10",     0, 1, 1, 1, 0, 0, 0, 32'h3008, 32'h3010, 32'h10, 32'h0, 5'd8, 2'd2);
    chk("lw10.exact", WD_W, 32'hDEADBEEF);

    step("sw20",     0, 1, 0, 0, 1, 0, 0, 32'h300C, 32'h3014, 32'h20, 32'h11223344, 5'd0, 2'd0);
    step("sb22",     0, 1, 0, 0, 1, 0, 1, 32'h3010, 32'h3018, 32'h22, 32'h000000F5, 5'd0, 2'd0);
    step("lw20",     0, 1, 1, 1, 0, 0, 0, 32'h3014, 32'h301C, 32'h20, 32'h0, 5'd9, 2'd2);
    chk("lw20.exact", WD_W, 32'h11F53344);
    step("lb22",     0, 1, 1, 1, 0, 0, 1, 32'h3018, 32'h3020, 32'h22, 32'h0, 5'd9, 2'd2);
    chk("lb22.exact", WD_W, 32'hFFFFFFF5);
    step("lb20",     0, 1, 1, 1, 0, 0, 1, 32'h301C, 32'h3024, 32'h20, 32'h0, 5'd9, 2'd2);
    chk("lb20.exact", WD_W, 32'h00000044);

    step("jal",      0, 1, 1, 1, 0, 1, 0, 32'h3000, 32'h3008, 32'h20, 32'h0, 5'd31, 2'd1);
    chk("jal.exact", WD_W, 32'h00003008);
    step("alu7",     0, 1, 0, 1, 0, 0, 0, 32'h3004, 32'h300C, 32'h7, 32'h0, 5'd2, 2'd1);
    chk("alu7.Fwd_exact", WD_W, 32'h7);

    step("stall_sw", 0, 0, 0, 1, 1, 0, 0, 32'h4000, 32'h4008, 32'h40, 32'h5, 5'd7, 2'd2);
    step("lw40_pre", 0, 1, 1, 1, 0, 0, 0, 32'h4004, 32'h400C, 32'h40, 32'h0, 5'd7, 2'd2);
    chk("stall.no_store", WD_W, 32'h0);
    step("stall2",   0, 0, 0, 0, 1, 0, 0, 32'h4008, 32'h4010, 32'h40, 32'h5, 5'd0, 2'd0);
    step("sw40",     0, 1, 0, 0, 1, 0, 0, 32'h4008, 32'h4010, 32'h40, 32'h5, 5'd0, 2'd0);
    step("lw40",     0, 1, 1, 1, 0, 0, 0, 32'h400C, 32'h4014, 32'h40, 32'h0, 5'd7, 2'd2);
    chk("sw40.one_store", WD_W, 32'h5);

    step("tn2",      0, 1, 0, 1, 0, 0, 0, 32'h5000, 32'h5008, 32'h1, 32'h0, 5'd1, 2'd2);
    chk("tn2.exact", 32'(Tnew_W), 32'd1);
    step("tn1",      0, 1, 0, 1, 0, 0, 0, 32'h5004, 32'h500C, 32'h2, 32'h0, 5'd1, 2'd1);
    chk("tn1.exact", 32'(Tnew_W), 32'd0);
    step("tn0",      0, 1, 0, 1, 0, 0, 0, 32'h5008, 32'h5010, 32'h3, 32'h0, 5'd1, 2'd0);
    chk("tn0.exact", 32'(Tnew_W), 32'd0);
    step("sw_oor",   0, 1, 0, 0, 1, 0, 0, 32'h500C, 32'h5014, 32'h3000, 32'hCAFEF00D, 5'd0, 2'd0);
    step("lw_oor",   0, 1, 1, 1, 0, 0, 0, 32'h5010, 32'h5018, 32'h3000, 32'h0, 5'd4, 2'd2);
    chk("oor.exact", WD_W, 32'h0);
    step("lw_last",  0, 1, 1, 1, 0, 0, 0, 32'h5014, 32'h501C, 32'h2FFC, 32'h0, 5'd4, 2'd2);

    step("sw10b",    0, 1, 0, 0, 1, 0, 0, 32'h6000, 32'h6008, 32'h10, 32'h99, 5'd0, 2'd0);
    step("rst_mid",  1, 1, 0, 1, 1, 0, 0, 32'h6004, 32'h600C, 32'h10, 32'h77, 5'd5, 2'd2);
    step("lw10_rst", 0, 1, 1, 1, 0, 0, 0, 32'h6008, 32'h6010, 32'h10, 32'h0, 5'd5, 2'd2);
    chk("rst_mid.mem", WD_W, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, pc;
      int          sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      a = $urandom_range(0, 255);
      else if (sel < 9) a = $urandom_range(12280, 12300);
      else              a = $urandom;
      pc = $urandom & 32'hFFFF_FFFC;
      step("rand", $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
           1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0, 1'($urandom),
           pc, pc + 32'd8, a, $urandom, 5'($urandom), 2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
